// File: rtl/rr_request_source.sv
// Requester-side front end for the weighted round-robin arbiter: one pending burst per
// channel, request/weight toward the grant engine, one beat per granted cycle.
// Optional starvation monitor: define RR_STARVE_MON_EN.
module rr_request_source #(
    parameter int CHANNELS     = 8,
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 64,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [CW-1:0]       load_chan,
    input  logic [WIDTH-1:0]    load_len,
    output logic [CHANNELS-1:0] request,
    input  logic [CHANNELS-1:0] grant,
    output logic [WIDTH-1:0]    weight,
    output logic                beat_valid,
    output logic [CW-1:0]       beat_chan,
    output logic                beat_last,
    output logic                grant_err,
    output logic [CHANNELS-1:0] starve_flag
);

    function automatic logic [CW-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (v[i]) lowest_set = CW'(i);
    endfunction

    logic [WIDTH-1:0] rem [CHANNELS];
    logic [CW-1:0]    g;
    logic             grant_any;
    logic             multi_hot;
    logic             load_fire;
    logic             beat_fire;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            request[i] = (rem[i] != '0);
    end

    assign g          = lowest_set(grant);
    assign grant_any  = (grant != '0);
    assign multi_hot  = ((grant & (grant - 1'b1)) != '0);
    assign load_ready = (rem[load_chan] == '0);
    assign load_fire  = load_valid && load_ready;
    // A grant to an idle channel is stale and produces neither a beat nor an error.
    assign beat_fire  = grant_any && (rem[g] != '0);
    assign weight     = grant_any ? rem[g] : '0;

    // Load and beat can never target the same channel: load needs rem==0, beat rem!=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                rem[i] <= '0;
            beat_valid <= 1'b0;
            beat_chan  <= '0;
            beat_last  <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            if (load_fire)
                rem[load_chan] <= load_len;
            if (beat_fire)
                rem[g] <= rem[g] - 1'b1;
            beat_valid <= beat_fire;
            if (beat_fire)
                beat_chan <= g;
            beat_last  <= beat_fire && (rem[g] == WIDTH'(1));
            grant_err  <= multi_hot;
        end
    end

`ifdef RR_STARVE_MON_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
        sat_inc = (c == SW'(STARVE_LIMIT)) ? c : c + 1'b1;
    endfunction

    logic [SW-1:0] wait_cnt [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (rem[i] == '0 || grant[i])
                    wait_cnt[i] <= '0;
                else
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            starve_flag[i] = (wait_cnt[i] == SW'(STARVE_LIMIT));
    end
`else
    // Monitor compiled out; the limit has no effect and the flags stay low.
    assign starve_flag = (STARVE_LIMIT < 0) ? '1 : '0;
`endif

endmodule

// File: tb/tb_rr_request_source.sv
// Self-checking bench for rr_request_source: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a per-channel reference model.
module tb_rr_request_source;
    localparam int CH = 8, W = 32, LIM = 4, CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [CW-1:0] load_chan;
    logic [W-1:0]  load_len;
    logic [CH-1:0] request;
    logic [CH-1:0] grant;
    logic [W-1:0]  weight;
    logic          beat_valid;
    logic [CW-1:0] beat_chan;
    logic          beat_last;
    logic          grant_err;
    logic [CH-1:0] starve_flag;

    rr_request_source #(.CHANNELS(CH), .WIDTH(W), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_chan(load_chan), .load_len(load_len), .request(request), .grant(grant),
        .weight(weight), .beat_valid(beat_valid), .beat_chan(beat_chan),
        .beat_last(beat_last), .grant_err(grant_err), .starve_flag(starve_flag)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int beats_seen = 0, lasts_seen = 0;

    // Reference model: remaining beats per channel, last observed outputs, wait counts.
    int unsigned m_rem [CH];
    int          m_wait[CH];
    bit          m_bv, m_bl, m_err;
    int          m_bc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int served(input logic [CH-1:0] gr);
        for (int i = 0; i < CH; i++)
            if (gr[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_rem[i] = 0;
            m_wait[i] = 0;
        end
        m_bv = 0; m_bl = 0; m_err = 0; m_bc = 0;
    endtask

    task automatic model_step();
        int s;
        bit ld;
        s  = served(grant);
        ld = load_valid && (m_rem[load_chan] == 0);
        for (int i = 0; i < CH; i++) begin
            if (m_rem[i] == 0 || grant[i]) m_wait[i] = 0;
            else if (m_wait[i] < LIM)      m_wait[i]++;
        end
        m_err = ($countones(grant) > 1);
        m_bv  = (s >= 0) && (m_rem[s] != 0);
        m_bl  = m_bv && (m_rem[s] == 1);
        if (m_bv) begin
            m_bc = s;
            m_rem[s]--;
        end
        if (ld) m_rem[load_chan] = load_len;
    endtask

    task automatic check_all();
        int s;
        logic [CH-1:0] req_e, stv_e;
        logic [W-1:0]  wt_e;
        s = served(grant);
        wt_e = (s >= 0) ? m_rem[s] : 0;
        for (int i = 0; i < CH; i++) begin
            req_e[i] = (m_rem[i] != 0);
`ifdef RR_STARVE_MON_EN
            stv_e[i] = (m_wait[i] == LIM);
`else
            stv_e[i] = 1'b0;
`endif
        end
        check("load_ready", load_ready, m_rem[load_chan] == 0);
        check("request", request, req_e);
        check("weight", weight, wt_e);
        check("beat_valid", beat_valid, m_bv);
        if (m_bv) check("beat_chan", beat_chan, m_bc);
        check("beat_last", beat_last, m_bl);
        check("grant_err", grant_err, m_err);
        check("starve_flag", starve_flag, stv_e);
        if (beat_valid === 1'b1) begin
            beats_seen++;
            if (beat_last === 1'b1) lasts_seen++;
        end
    endtask

    task automatic cycle(input logic lv, input int lc, input int unsigned ll, input logic [CH-1:0] gr);
        load_valid = lv; load_chan = CW'(lc); load_len = ll; grant = gr;
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_request", request, 0);
        check("reset_beat_valid", beat_valid, 0);
        check("reset_grant_err", grant_err, 0);
        check("reset_starve", starve_flag, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic lv; int lc; int unsigned ll; logic [CH-1:0] gr;
        logic rdy; int unsigned wt; logic [CH-1:0] req; logic bv; int bc; logic bl; logic err;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int b0, l0, s;
        logic [CH-1:0] gr;
        logic exp_flag;

        tbl[0] = '{1, 2, 3, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
        tbl[1] = '{0, 2, 0, 8'h04, 0, 3, 8'h04, 0, 0, 0, 0};
        tbl[2] = '{0, 2, 0, 8'h04, 0, 2, 8'h04, 1, 2, 0, 0};
        tbl[3] = '{0, 2, 0, 8'h04, 0, 1, 8'h04, 1, 2, 0, 0};
        tbl[4] = '{0, 2, 0, 8'h00, 1, 0, 8'h00, 1, 2, 1, 0};
        tbl[5] = '{1, 0, 2, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
        tbl[6] = '{1, 3, 5, 8'h00, 1, 0, 8'h01, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 8'h09, 0, 2, 8'h09, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 8'h00, 0, 0, 8'h09, 1, 0, 0, 1};
        tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 8'h09, 0, 0, 0, 0};

        load_valid = 0; load_chan = 0; load_len = 0; grant = 0;
        @(negedge clk);
        do_reset();

        // Directed table: single burst on ch2, then multi-hot grant with ch0/ch3 pending.
        for (int k = 0; k < 10; k++) begin
            load_valid = tbl[k].lv; load_chan = CW'(tbl[k].lc);
            load_len = tbl[k].ll; grant = tbl[k].gr;
            #1;
            check($sformatf("tbl%0d_ready", k), load_ready, tbl[k].rdy);
            check($sformatf("tbl%0d_weight", k), weight, tbl[k].wt);
            check($sformatf("tbl%0d_request", k), request, tbl[k].req);
            check($sformatf("tbl%0d_beat_valid", k), beat_valid, tbl[k].bv);
            if (tbl[k].bv) check($sformatf("tbl%0d_beat_chan", k), beat_chan, tbl[k].bc);
            check($sformatf("tbl%0d_beat_last", k), beat_last, tbl[k].bl);
            check($sformatf("tbl%0d_grant_err", k), grant_err, tbl[k].err);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // Grant withdrawn mid-burst, then resumed.
        do_reset();
        cycle(1, 0, 20, 0);
        b0 = beats_seen; l0 = lasts_seen;
        repeat (16) cycle(0, 0, 0, 8'h01);
        repeat (2) cycle(0, 0, 0, 8'h00);
        check("withdraw_beats", beats_seen - b0, 16);
        check("withdraw_request0", request[0], 1);
        check("withdraw_no_last", lasts_seen - l0, 0);
        repeat (4) cycle(0, 0, 0, 8'h01);
        repeat (2) cycle(0, 0, 0, 8'h00);
        check("resume_beats", beats_seen - b0, 20);
        check("resume_last", lasts_seen - l0, 1);
        check("resume_request0", request[0], 0);

        // Load refused while busy; zero-length load is a no-op.
        cycle(1, 5, 2, 0);
        load_chan = 5;
        #1 check("busy_load_ready", load_ready, 0);
        cycle(1, 5, 9, 0);
        repeat (2) cycle(0, 5, 0, 8'h20);
        cycle(0, 5, 0, 0);
        cycle(1, 5, 0, 0);
        cycle(0, 5, 0, 0);
        check("zero_len_request5", request[5], 0);

        // Asynchronous reset mid-burst.
        cycle(1, 1, 9, 0);
        repeat (2) cycle(0, 1, 0, 8'h02);
        grant = 8'h02;
        #2 reset = 1'b1;
        #1;
        check("async_request", request, 0);
        check("async_beat_valid", beat_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        b0 = beats_seen;
        repeat (3) cycle(0, 1, 0, 8'h02);
        check("post_reset_beats", beats_seen - b0, 0);

        // Starvation: ch7 pending for LIM cycles, then granted.
        do_reset();
        cycle(1, 7, 3, 0);
        repeat (4) cycle(0, 7, 0, 0);
`ifdef RR_STARVE_MON_EN
        exp_flag = 1'b1;
`else
        exp_flag = 1'b0;
`endif
        #1 check("starve_set", starve_flag[7], exp_flag);
        cycle(0, 7, 0, 8'h80);
        #1 check("starve_clear", starve_flag[7], 0);
        repeat (3) cycle(0, 7, 0, 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s = $urandom_range(0, 9);
            gr = 0;
            if (s <= 5) begin
                int pick = $urandom_range(0, CH - 1);
                for (int j = 0; j < CH; j++)
                    if (m_rem[(pick + j) % CH] != 0) begin
                        gr = CH'(1) << ((pick + j) % CH);
                        break;
                    end
            end else if (s == 7) begin
                gr = CH'($urandom);
            end else if (s >= 8) begin
                gr = CH'(1) << $urandom_range(0, CH - 1);
            end
            cycle($urandom_range(0, 1), $urandom_range(0, CH - 1), $urandom_range(0, 6), gr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
